// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of bitstream words needed to cover the whole chain (ceil division).
  function automatic int unsigned words_needed(input int unsigned chain_len,
                                               input int unsigned word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

  // Bits actually shifted from the final word; a full word when the chain is an exact multiple.
  function automatic int unsigned tail_bits(input int unsigned chain_len,
                                            input int unsigned word_w);
    return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
  endfunction

endpackage

// File: rtl/ccff_bitstream_loader_piso.sv
// Parallel-in/serial-out shifter, MSB first, tracking how many valid bits remain.
module ccff_piso #(
  parameter int WORD_W = 32,
  parameter int LEN_W  = $clog2(WORD_W + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              flush,
  input  logic              load,
  input  logic [LEN_W-1:0]  load_len,
  input  logic [WORD_W-1:0] load_data,
  input  logic              shift,
  output logic              head_bit,
  output logic              empty,
  output logic              last
);

  logic [WORD_W-1:0] sreg;
  logic [LEN_W-1:0]  cnt;

  // Load takes priority over shift: the outgoing last bit leaves on the same edge the new word arrives.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (flush) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= load_len;
    end else if (shift && (cnt != '0)) begin
      sreg <= sreg << 1;
      cnt  <= cnt - 1'b1;
    end
  end

  assign head_bit = sreg[WORD_W-1];
  assign empty    = (cnt == '0);
  assign last     = (cnt == LEN_W'(1));

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams configuration words MSB-first into the fabric configuration chain head.
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 4096,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
);

  localparam int unsigned WORDS = words_needed(CHAIN_LEN, WORD_W);
  localparam int unsigned TAIL  = tail_bits(CHAIN_LEN, WORD_W);
  localparam int          LEN_W = $clog2(WORD_W + 1);
  localparam int          WC_W  = $clog2(WORDS + 1);

  state_t           state;
  logic [WC_W-1:0]  word_cnt;
  logic             head_hold;
  logic             in_load;
  logic             accept;
  logic             flush;
  logic             last_bit;
  logic             p_head;
  logic             p_empty;
  logic             p_last;
  logic [LEN_W-1:0] load_len;

  assign in_load       = (state == LOAD);
  // abort gates the current cycle so bit_count always equals the number of shift_en pulses.
  assign ccff_shift_en = in_load && !abort && !p_empty;
  assign word_ready    = in_load && !abort && (p_empty || p_last) &&
                         (word_cnt < WC_W'(WORDS));
  assign accept        = word_valid && word_ready;
  assign flush         = abort || (start && !in_load);
  assign load_len      = (word_cnt == WC_W'(WORDS - 1)) ? LEN_W'(TAIL) : LEN_W'(WORD_W);
  assign last_bit      = ccff_shift_en && (bit_count == CNT_W'(CHAIN_LEN - 1));
  // While starved the chain head keeps the last bit driven.
  assign ccff_head     = ccff_shift_en ? p_head : head_hold;

  ccff_piso #(
    .WORD_W(WORD_W),
    .LEN_W (LEN_W)
  ) u_piso (
    .prog_clk (prog_clk),
    .pReset_n (pReset_n),
    .flush    (flush),
    .load     (accept),
    .load_len (load_len),
    .load_data(word_data),
    .shift    (ccff_shift_en),
    .head_bit (p_head),
    .empty    (p_empty),
    .last     (p_last)
  );

  // Load-control FSM with word/bit counters and registered status outputs.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bit_count <= '0;
      word_cnt  <= '0;
      head_hold <= 1'b0;
    end else begin
      if (ccff_shift_en) head_hold <= p_head;
      if (accept)        word_cnt  <= word_cnt + 1'b1;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state     <= LOAD;
              busy      <= 1'b1;
              done      <= 1'b0;
              bit_count <= '0;
              word_cnt  <= '0;
            end
          end
          LOAD: begin
            if (ccff_shift_en) begin
              if (bit_count < CNT_W'(CHAIN_LEN)) bit_count <= bit_count + 1'b1;
              if (last_bit) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Writer side of the configuration-chain interface that feeds the fabric's LUT SRAM and mode bits: the bits read by frac_lut4 and the other configurable cells.
- Accepts configuration words over a valid/ready stream and serialises them MSB-first into the configuration flip-flop chain head.
- Drives the chain shift-enable and counts exactly CHAIN_LEN bits.
- Sits between the bitstream source (Wishbone/GPIO bridge) and the fabric ccff_head pin.

Parameters:
- WORD_W, 32, width of one bitstream word.
- CHAIN_LEN, 4096, total configuration bits in the chain.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (derived; not overridden).

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- pReset_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; begin a load (honoured only in IDLE or DONE).
- abort  in  1  1-cycle pulse; terminate the load and return to IDLE.
- word_data  in  WORD_W  bitstream word; bit WORD_W-1 is shifted first.
- word_valid  in  1  word_data valid.
- word_ready  out  1  loader accepts word_data this cycle.
- ccff_head  out  1  serial config bit to the chain head.
- ccff_shift_en  out  1  chain captures ccff_head on this prog_clk edge.
- busy  out  1  high in LOAD.
- done  out  1  level; high in DONE until next start/abort.
- bit_count  out  CNT_W  bits shifted so far in the current load.

Behaviour:
- Reset: all outputs 0; state IDLE; shift register cleared; bit counter cleared; word-held flag cleared.
- States:
  - IDLE: start -> LOAD; bit_count cleared.
  - LOAD: start ignored; bit_count==CHAIN_LEN -> DONE; abort -> IDLE.
  - DONE: done=1; start -> LOAD; abort -> IDLE.
  - abort has priority over every other transition.
- word_ready: combinational; high in LOAD when the shift register is empty, or holds exactly one remaining valid bit that shifts this cycle, AND the words accepted so far are fewer than ceil(CHAIN_LEN/WORD_W).
- Handshake:
  - A word transfers when word_valid and word_ready are both high.
  - word_valid may be held without ready and data must stay stable; a violation is undefined.
  - The accepted word is loaded into the shift register. Its MSB drives ccff_head from the next cycle, with ccff_shift_en=1.
- Shifting:
  - Each cycle with a valid bit held: ccff_shift_en=1, ccff_head=current bit, register shifts left, bit_count+1.
  - Back-to-back valid words give continuous shifting with no bubble.
- Starvation: shift register empty and no word accepted -> ccff_shift_en=0, ccff_head holds its last value, bit_count holds.
- Partial last word (CHAIN_LEN mod WORD_W != 0): only the upper (CHAIN_LEN mod WORD_W) bits are shifted; the lower bits are discarded; no extra ccff_shift_en pulse.
- Exact count: ccff_shift_en asserts exactly CHAIN_LEN times per completed load. On the cycle bit_count reaches CHAIN_LEN the state is DONE, ccff_shift_en=0 and word_ready=0.
- start during LOAD: ignored. start in DONE restarts: bit_count->0 and done->0 the next cycle.
- abort mid-load: the next cycle has ccff_shift_en=0, busy=0, shift register flushed; bit_count holds the partial value for debug until the next start.
- Reset mid-load: immediate return to reset values; the chain is partially programmed; software must reload.
- start and abort in the same cycle: abort wins.
- bit_count saturates at CHAIN_LEN.

Decomposition:
- Package ccff_loader_pkg holds:
  - State enum {IDLE, LOAD, DONE}, 2 bits.
  - Function words_needed(CHAIN_LEN, WORD_W) = ceil division.
  - Function tail_bits(CHAIN_LEN, WORD_W).
- One sub-module is natural: ccff_piso, the WORD_W parallel-in/serial-out shifter. It has load, shift, a valid-bit counter, and empty/last flags, plus a load-length input for the partial last word.
- The FSM, word counter and bit counter stay in the top module.

Test Plan (WORD_W=8, CHAIN_LEN=20 unless stated):
- Reset values: assert pReset_n=0 mid-LOAD -> all outputs 0 asynchronously; after release, state IDLE and word_ready=0.
- Streaming load: start, then words 0xA5, 0x3C, 0xF0 with valid held high -> ccff_head sequence 10100101 00111100 1111, 20 consecutive shift_en cycles, third word's low nibble dropped, done=1, bit_count=20, word_ready=0 after 3 words.
- Starvation: word_valid low for 5 cycles after the first word is drained -> shift_en=0 for exactly those cycles, bit_count stays 8, load completes correctly afterwards.
- Abort: abort at bit_count=11 -> next cycle busy=0, shift_en=0, bit_count=11; new start -> bit_count=0 and a full 20-bit load succeeds.
- Exact multiple: CHAIN_LEN=16, words 0xFF, 0x00 -> exactly 16 shift_en pulses, no third word accepted, done asserted the cycle after the last bit.
- Corner: start pulsed during LOAD is ignored (bit_count is not reset); start and abort together in DONE -> IDLE, done=0.
